// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types for the instruction/data memory bus arbiter
// Purpose: FSM state and grant-side enums, plus a helper for round-robin selection.
// Ports: none (package).
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    Idle      = 2'd0,
    GrantInst = 2'd1,
    GrantData = 2'd2
  } mem_arbiter_fsm_t;

  typedef enum logic {
    GrantSideInst = 1'b0,
    GrantSideData = 1'b1
  } grant_t;

  // On a tie the side that was not served last wins.
  function automatic grant_t other_side(input grant_t g);
    return (g == GrantSideInst) ? GrantSideData : GrantSideInst;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - request/response and memory bus signals around the arbiter
// Purpose: bundles the instruction side, data side and shared memory bus.
// Modports:
//   slave  - arbiter view: requests and mem_ack/mem_rd_dat in; acks, rd_dat, mem_* out
//   master - environment view: the opposite directions
interface mem_bus_arbiter_if #(
  parameter int Width = 32
);

  logic                 inst_mem_en;
  logic [Width-1:0]     inst_mem_addr;
  logic                 inst_mem_ack;
  logic                 inst_mem_err;

  logic                 data_mem_en;
  logic                 data_mem_we;
  logic [Width-1:0]     data_mem_addr;
  logic [Width/8-1:0]   data_mem_sel;
  logic [Width-1:0]     data_mem_wr_dat;
  logic                 data_mem_ack;
  logic                 data_mem_err;

  logic [Width-1:0]     rd_dat;

  logic                 mem_en;
  logic                 mem_we;
  logic [Width-1:0]     mem_addr;
  logic [Width/8-1:0]   mem_sel;
  logic [Width-1:0]     mem_wr_dat;
  logic                 mem_ack;
  logic [Width-1:0]     mem_rd_dat;

  modport slave (
    input  inst_mem_en, inst_mem_addr,
    input  data_mem_en, data_mem_we, data_mem_addr, data_mem_sel, data_mem_wr_dat,
    input  mem_ack, mem_rd_dat,
    output inst_mem_ack, inst_mem_err, data_mem_ack, data_mem_err, rd_dat,
    output mem_en, mem_we, mem_addr, mem_sel, mem_wr_dat
  );

  modport master (
    output inst_mem_en, inst_mem_addr,
    output data_mem_en, data_mem_we, data_mem_addr, data_mem_sel, data_mem_wr_dat,
    output mem_ack, mem_rd_dat,
    input  inst_mem_ack, inst_mem_err, data_mem_ack, data_mem_err, rd_dat,
    input  mem_en, mem_we, mem_addr, mem_sel, mem_wr_dat
  );

endinterface

// File: rtl/mem_bus_arbiter_timeout.sv
// rtl/mem_bus_arbiter_timeout.sv - grant-cycle counter with expiry flag
// Purpose: counts grant cycles without mem_ack; flags expiry at TimeoutCycles-1.
// Only instantiated when MEM_ARBITER_TIMEOUT_EN is defined.
// Ports:
//   i_clock, i_reset - clock, synchronous active-high reset
//   i_clear          - restart from zero (state change)
//   i_count          - a grant cycle passed without mem_ack
//   o_expired        - counter has reached TimeoutCycles-1
module mem_arbiter_timeout #(
  parameter int TimeoutCycles = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);

  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_count && (r_count != LastCount)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == LastCount);

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one memory port between inst and data
// Purpose: grants one transaction at a time, muxes the granted side onto the bus and
//   routes the combinational mem_ack / read data back to that side only.
// Optional feature: MEM_ARBITER_TIMEOUT_EN aborts a grant after TimeoutCycles cycles
//   without mem_ack (ack+err pulse); otherwise err outputs are tied 0.
// Ports:
//   i_clock - system clock, rising edge
//   i_reset - synchronous, active-high
//   bus     - mem_bus_arbiter_if.slave (inst/data request sides and memory bus)
module mem_bus_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int Width         = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                i_clock,
  input  logic                i_reset,
  mem_bus_arbiter_if.slave    bus
);

  localparam int SelW = Width / 8;

  mem_arbiter_fsm_t r_state;
  mem_arbiter_fsm_t w_next_state;
  grant_t           r_last_grant;
  grant_t           w_next_last_grant;
  logic             w_expired;

  logic             w_mem_en;
  logic             w_mem_we;
  logic [Width-1:0] w_mem_addr;
  logic [SelW-1:0]  w_mem_sel;
  logic [Width-1:0] w_mem_wr_dat;
  logic             w_inst_ack;
  logic             w_inst_err;
  logic             w_data_ack;
  logic             w_data_err;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= Idle;
      r_last_grant <= GrantSideData;
    end else begin
      r_state      <= w_next_state;
      r_last_grant <= w_next_last_grant;
    end
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic w_count_cycle;
  logic w_clear_count;

  // Any state change restarts the count, which covers both Idle->Grant and
  // back-to-back Grant->Grant hand-overs.
  assign w_count_cycle = (r_state != Idle) && !bus.mem_ack;
  assign w_clear_count = (w_next_state != r_state);

  mem_arbiter_timeout #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_clear_count),
    .i_count  (w_count_cycle),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_next_state      = r_state;
    w_next_last_grant = r_last_grant;
    w_mem_en          = 1'b0;
    w_mem_we          = 1'b0;
    w_mem_addr        = '0;
    w_mem_sel         = '0;
    w_mem_wr_dat      = '0;
    w_inst_ack        = 1'b0;
    w_inst_err        = 1'b0;
    w_data_ack        = 1'b0;
    w_data_err        = 1'b0;

    // Reset silences the bus in the same cycle; the open bus cycle is dropped.
    if (i_reset) begin
      w_next_state = Idle;
    end else begin
      case (r_state)
        Idle: begin
          if (bus.inst_mem_en && bus.data_mem_en) begin
            w_next_state = (other_side(r_last_grant) == GrantSideInst) ? GrantInst : GrantData;
          end else if (bus.inst_mem_en) begin
            w_next_state = GrantInst;
          end else if (bus.data_mem_en) begin
            w_next_state = GrantData;
          end
        end

        GrantInst: begin
          w_mem_en   = bus.inst_mem_en;
          w_mem_addr = bus.inst_mem_addr;
          w_mem_sel  = '1;
          if (!bus.inst_mem_en) begin
            w_next_state = Idle;
          end else if (bus.mem_ack) begin
            w_inst_ack        = 1'b1;
            w_next_last_grant = GrantSideInst;
            w_next_state      = bus.data_mem_en ? GrantData : Idle;
          end else if (w_expired) begin
            w_mem_en          = 1'b0;
            w_inst_ack        = 1'b1;
            w_inst_err        = 1'b1;
            w_next_last_grant = GrantSideInst;
            w_next_state      = Idle;
          end
        end

        GrantData: begin
          w_mem_en     = bus.data_mem_en;
          w_mem_we     = bus.data_mem_we;
          w_mem_addr   = bus.data_mem_addr;
          w_mem_sel    = bus.data_mem_sel;
          w_mem_wr_dat = bus.data_mem_wr_dat;
          if (!bus.data_mem_en) begin
            w_next_state = Idle;
          end else if (bus.mem_ack) begin
            w_data_ack        = 1'b1;
            w_next_last_grant = GrantSideData;
            w_next_state      = bus.inst_mem_en ? GrantInst : Idle;
          end else if (w_expired) begin
            w_mem_en          = 1'b0;
            w_data_ack        = 1'b1;
            w_data_err        = 1'b1;
            w_next_last_grant = GrantSideData;
            w_next_state      = Idle;
          end
        end

        default: begin
          w_next_state = Idle;
        end
      endcase
    end
  end

  assign bus.mem_en       = w_mem_en;
  assign bus.mem_we       = w_mem_we;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_sel      = w_mem_sel;
  assign bus.mem_wr_dat   = w_mem_wr_dat;
  assign bus.inst_mem_ack = w_inst_ack;
  assign bus.inst_mem_err = w_inst_err;
  assign bus.data_mem_ack = w_data_ack;
  assign bus.data_mem_err = w_data_err;
  // Read data is only meaningful alongside an ack, so hold it at zero otherwise.
  assign bus.rd_dat       = (w_inst_ack || w_data_ack) ? bus.mem_rd_dat : '0;

endmodule
